m_load_unit: RTL and testbench
==============================

M_LOAD_UNIT -- requirements
Module: m_load_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the WAIT-state cycle limit (1..255), used only when LOAD_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  a load request is present.
REQ-005 SHALL have port req_ready  out  1  the unit accepts a request this cycle.
REQ-006 SHALL have port req_addr  in  32  byte address of the load.
REQ-007 SHALL have port req_op  in  3  load type: 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU; other values mean no load.
REQ-008 SHALL have port req_flush  in  1  interrupt/exception flush of the in-flight load.
REQ-009 SHALL have port mem_rd_en  out  1  data-memory read strobe.
REQ-010 SHALL have port mem_addr  out  32  word-aligned read address.
REQ-011 SHALL have port mem_rd_ack  in  1  read data valid; variable latency of 1 cycle or more.
REQ-012 SHALL have port mem_rd_data  in  32  raw memory word.
REQ-013 SHALL have port rsp_valid  out  1  the result is held for the consumer.
REQ-014 SHALL have port rsp_ready  in  1  the consumer takes the result.
REQ-015 SHALL have port rsp_data  out  32  aligned and extended load result.
REQ-016 SHALL have port rsp_exc  out  5  exception code: 0 none, 4 AdEL, 7 DBE.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, HOLD, DRAIN.
REQ-018 SHALL drive req_ready = 1 only in IDLE with req_flush = 0; accept = req_valid & req_ready & req_op in 1..5; any other req_op SHALL be ignored with no state change.
REQ-019 SHALL, on accept, register addr and op; an aligned request SHALL go to WAIT; a misaligned request (LW with addr[1:0] != 0, LH/LHU with addr[0] = 1) SHALL go to HOLD with rsp_exc = 4, rsp_data = 0 and no memory read.
REQ-020 SHALL assert mem_rd_en in every WAIT cycle; mem_addr SHALL be {addr[31:2], 2'b00} in WAIT and 0 otherwise.
REQ-021 SHALL, on mem_rd_ack in WAIT, register the extracted result and go to HOLD the next cycle, giving rsp_valid one cycle after ack.
REQ-022 SHALL extract as follows: LW gives the full word; LH/LHU use half addr[1] (0 gives [15:0], 1 gives [31:16]), sign- or zero-extended; LB/LBU use byte lane addr[1:0] (bits [8k+7:8k]), sign- or zero-extended.
REQ-023 SHALL hold rsp_valid, rsp_data and rsp_exc stable in HOLD until rsp_ready = 1, then go to IDLE; rsp_data and rsp_exc SHALL be 0 whenever rsp_valid = 0.
REQ-024 SHALL ignore mem_rd_ack outside WAIT.
REQ-025 SHALL handle flush in WAIT by going to DRAIN: mem_rd_en stays 1 until ack, then go to IDLE with no rsp_valid. A flush and an ack in the same WAIT cycle SHALL go directly to IDLE.
REQ-026 SHALL handle flush in HOLD by going to IDLE and dropping the response; flush has priority over rsp_ready.
REQ-027 SHALL give at most one outstanding read; a new request SHALL be accepted one cycle after returning to IDLE.

Reset
REQ-028 SHALL, while reset = 0, immediately force state IDLE and every registered output and internal register to 0; on release req_ready = 1.
REQ-029 SHALL, on reset mid-WAIT or mid-DRAIN, abandon the read; a late ack after release SHALL be ignored.

Configuration
REQ-030 SHALL, with LOAD_TIMEOUT_EN defined, count WAIT cycles in an 8-bit counter cleared on entering WAIT; when the count reaches TIMEOUT_CYCLES with no ack, go to HOLD with rsp_exc = 7 and rsp_data = 0. DRAIN SHALL use the same limit and go to IDLE silently.
REQ-031 SHALL, without LOAD_TIMEOUT_EN, have no counter; WAIT and DRAIN last until ack and rsp_exc is never 7.

Structure
REQ-032 SHALL take the op codes, exception codes (AdEL = 4, DBE = 7) and the FSM state enum from the shared package m_load_pkg.
REQ-033 SHALL place the extraction logic in the combinational sub-module m_load_align (inputs op, addr[1:0], word; output data).

Verification
REQ-034 SHALL check LB: addr 0x103, data 0x80FF_0102, ack after 3 cycles -> rsp_data 0xFFFF_FF80, rsp_exc 0, rsp_valid one cycle after ack.
REQ-035 SHALL check LHU: addr 0x102, data 0x8001_1234 -> 0x0000_8001; and LH on the same inputs -> 0xFFFF_8001.
REQ-036 SHALL check misaligned LW: addr 0x101 -> mem_rd_en never asserted, rsp_exc 4, rsp_data 0.
REQ-037 SHALL check flush in WAIT before ack -> mem_rd_en held until ack, no rsp_valid, req_ready = 1 one cycle after ack.
REQ-038 SHALL check backpressure: rsp_ready low for 5 cycles in HOLD -> outputs stable, req_ready = 0 throughout.
REQ-039 SHALL check timeout with LOAD_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> HOLD after 4 WAIT cycles, rsp_exc 7; a later ack is ignored.

Source files
------------

// File: rtl/m_load_pkg.sv
// Shared definitions for the load unit: op codes, exception codes and FSM states.
package m_load_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LB  = 3'd4;
  localparam logic [2:0] OP_LBU = 3'd5;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } loadState_t;

  function automatic logic isLoadOp(input logic [2:0] op);
    return (op >= OP_LW) && (op <= OP_LBU);
  endfunction

  // Words need a 4-byte boundary, halves a 2-byte boundary; bytes never fault.
  function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] addrLo);
    case (op)
      OP_LW:         return addrLo != 2'b00;
      OP_LH, OP_LHU: return addrLo[0];
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/m_load_align.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module m_load_align
  import m_load_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data
);

  logic signed [15:0] halfSel;
  logic signed [7:0]  byteSel;

  always_comb begin
    halfSel = addr[1] ? word[31:16] : word[15:0];
    case (addr)
      2'd0:    byteSel = word[7:0];
      2'd1:    byteSel = word[15:8];
      2'd2:    byteSel = word[23:16];
      default: byteSel = word[31:24];
    endcase
    case (op)
      OP_LW:   data = word;
      OP_LH:   data = {{16{halfSel[15]}}, halfSel};
      OP_LHU:  data = {16'h0000, halfSel};
      OP_LB:   data = {{24{byteSel[7]}}, byteSel};
      OP_LBU:  data = {24'h000000, byteSel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/m_load_unit.sv
// Load unit: one outstanding aligned read, flush/drain handling, held response.
// Optional WAIT/DRAIN timeout enabled by defining LOAD_TIMEOUT_EN.
module m_load_unit
  import m_load_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  input  logic              req_flush,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        rsp_exc
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  loadState_t        state;
  logic [DATA_W-1:0] addrReg;
  logic [2:0]        opReg;
  logic [DATA_W-1:0] rspDataReg;
  logic [4:0]        rspExcReg;
  logic [DATA_W-1:0] alignedData;
  logic              accept;

`ifdef LOAD_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] waitCnt;
`endif

  m_load_align uAlign (
    .op   (opReg),
    .addr (addrReg[1:0]),
    .word (mem_rd_data),
    .data (alignedData)
  );

  assign req_ready = (state == ST_IDLE) && !req_flush;
  assign accept    = req_valid && req_ready && isLoadOp(req_op);
  // DRAIN keeps the strobe up so the abandoned read still completes on the bus.
  assign mem_rd_en = (state == ST_WAIT) || (state == ST_DRAIN);
  assign mem_addr  = (state == ST_WAIT) ? {addrReg[31:2], 2'b00} : '0;
  assign rsp_valid = (state == ST_HOLD);
  assign rsp_data  = rsp_valid ? rspDataReg : '0;
  assign rsp_exc   = rsp_valid ? rspExcReg : EXC_NONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      addrReg    <= '0;
      opReg      <= '0;
      rspDataReg <= '0;
      rspExcReg  <= EXC_NONE;
`ifdef LOAD_TIMEOUT_EN
      waitCnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addrReg <= req_addr;
            opReg   <= req_op;
`ifdef LOAD_TIMEOUT_EN
            waitCnt <= '0;
`endif
            if (isMisaligned(req_op, req_addr[1:0])) begin
              state      <= ST_HOLD;
              rspDataReg <= '0;
              rspExcReg  <= EXC_ADEL;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
`ifdef LOAD_TIMEOUT_EN
          waitCnt <= waitCnt + 8'd1;
`endif
          if (mem_rd_ack) begin
            if (req_flush) begin
              state <= ST_IDLE;
            end else begin
              state      <= ST_HOLD;
              rspDataReg <= alignedData;
              rspExcReg  <= EXC_NONE;
            end
          end else if (req_flush) begin
            state <= ST_DRAIN;
`ifdef LOAD_TIMEOUT_EN
          end else if (waitCnt == TIMEOUT_LAST) begin
            state      <= ST_HOLD;
            rspDataReg <= '0;
            rspExcReg  <= EXC_DBE;
`endif
          end
        end
        ST_HOLD: begin
          if (req_flush || rsp_ready) state <= ST_IDLE;
        end
        default: begin
`ifdef LOAD_TIMEOUT_EN
          // The count keeps running from WAIT, so the limit bounds the whole read.
          waitCnt <= waitCnt + 8'd1;
          if (mem_rd_ack || waitCnt >= TIMEOUT_LAST) state <= ST_IDLE;
`else
          if (mem_rd_ack) state <= ST_IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_load_unit.sv
// Bench for m_load_unit: directed literal cases plus randomized traffic vs. a transaction model.
module tb_m_load_unit;
  import m_load_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_op = '0;
  logic        req_flush = 1'b0;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_rd_ack = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_exc;

  always #5 clk = ~clk;

  m_load_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_op      (req_op),
    .req_flush   (req_flush),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_ack  (mem_rd_ack),
    .mem_rd_data (mem_rd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_exc     (rsp_exc)
  );

  int tests = 0;
  int fails = 0;

  task automatic chkB(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chkW(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: a read is either outstanding or not, a result is either held or not.
  bit          pendingRead = 1'b0;
  bit          dropOnAck = 1'b0;
  bit          haveResult = 1'b0;
  logic [31:0] mAddr = '0;
  logic [2:0]  mOp = '0;
  logic [31:0] resultData = '0;
  logic [4:0]  resultExc = '0;
  int          waitCnt = 0;

  function automatic logic [31:0] refExtract(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] v;
    v = 32'h0;
    if (op == 3'd1) begin
      v = word;
    end else if (op == 3'd2 || op == 3'd3) begin
      v = (word >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
      if (op == 3'd2 && v >= 32'h8000) v = v - 32'h1_0000;
    end else if (op == 3'd4 || op == 3'd5) begin
      v = (word >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
      if (op == 3'd4 && v >= 32'h80) v = v - 32'h100;
    end
    return v;
  endfunction

  function automatic bit refMisaligned(input logic [2:0] op, input logic [31:0] addr);
    return (op == 3'd1 && addr[1:0] != 2'b00) || ((op == 3'd2 || op == 3'd3) && addr[0]);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pendingRead = 1'b0;
      dropOnAck   = 1'b0;
      haveResult  = 1'b0;
      resultData  = '0;
      resultExc   = '0;
      waitCnt     = 0;
    end else if (haveResult) begin
      if (req_flush || rsp_ready) haveResult = 1'b0;
    end else if (pendingRead) begin
      waitCnt++;
      if (mem_rd_ack) begin
        pendingRead = 1'b0;
        if (!dropOnAck && !req_flush) begin
          haveResult = 1'b1;
          resultData = refExtract(mOp, mAddr, mem_rd_data);
          resultExc  = 5'd0;
        end
      end else if (!dropOnAck && req_flush) begin
        dropOnAck = 1'b1;
      end
`ifdef LOAD_TIMEOUT_EN
      else if (waitCnt >= TO) begin
        pendingRead = 1'b0;
        if (!dropOnAck) begin
          haveResult = 1'b1;
          resultData = '0;
          resultExc  = 5'd7;
        end
      end
`endif
    end else if (req_valid && !req_flush && req_op >= 3'd1 && req_op <= 3'd5) begin
      mAddr = req_addr;
      mOp   = req_op;
      if (refMisaligned(req_op, req_addr)) begin
        haveResult = 1'b1;
        resultData = '0;
        resultExc  = 5'd4;
      end else begin
        pendingRead = 1'b1;
        dropOnAck   = 1'b0;
        waitCnt     = 0;
      end
    end
  end

  bit checkEn = 1'b0;

  always @(negedge clk) begin
    if (checkEn) begin
      chkB("req_ready", req_ready, !pendingRead && !haveResult && !req_flush);
      chkB("mem_rd_en", mem_rd_en, pendingRead);
      chkW("mem_addr", mem_addr, (pendingRead && !dropOnAck) ? {mAddr[31:2], 2'b00} : 32'h0);
      chkB("rsp_valid", rsp_valid, haveResult);
      chkW("rsp_data", rsp_data, haveResult ? resultData : 32'h0);
      chkW("rsp_exc", 32'(rsp_exc), haveResult ? 32'(resultExc) : 32'h0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    cyc();
    req_valid = 1'b0;
    req_op    = 3'd0;
  endtask

  // Ack lands in the n-th WAIT cycle; rsp_valid must still be low in that cycle.
  task automatic ackAfter(input int n, input logic [31:0] data);
    repeat (n - 1) cyc();
    mem_rd_ack  = 1'b1;
    mem_rd_data = data;
    chkB("valid_in_ack_cycle", rsp_valid, 1'b0);
    cyc();
    mem_rd_ack = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chkB("rst_mem_rd_en", mem_rd_en, 1'b0);
    chkB("rst_rsp_valid", rsp_valid, 1'b0);
    chkW("rst_rsp_data", rsp_data, 32'h0);
    reset   = 1'b1;
    checkEn = 1'b1;
    cyc();
    chkB("post_rst_req_ready", req_ready, 1'b1);

    issue(OP_LB, 32'h103);
    chkB("lb_rd_en", mem_rd_en, 1'b1);
    chkW("lb_mem_addr", mem_addr, 32'h100);
    ackAfter(3, 32'h80FF_0102);
    chkB("lb_valid", rsp_valid, 1'b1);
    chkW("lb_data", rsp_data, 32'hFFFF_FF80);
    chkW("lb_exc", 32'(rsp_exc), 32'h0);
    consume();
    chkB("lb_done", rsp_valid, 1'b0);

    issue(OP_LHU, 32'h102);
    ackAfter(1, 32'h8001_1234);
    chkW("lhu_data", rsp_data, 32'h0000_8001);
    consume();
    issue(OP_LH, 32'h102);
    ackAfter(2, 32'h8001_1234);
    chkW("lh_data", rsp_data, 32'hFFFF_8001);
    consume();

    issue(OP_LW, 32'h101);
    chkB("mis_rd_en", mem_rd_en, 1'b0);
    chkB("mis_valid", rsp_valid, 1'b1);
    chkW("mis_exc", 32'(rsp_exc), 32'h4);
    chkW("mis_data", rsp_data, 32'h0);
    consume();

    issue(OP_LW, 32'h200);
    req_flush = 1'b1;
    cyc();
    req_flush = 1'b0;
    chkB("drain_rd_en", mem_rd_en, 1'b1);
    chkB("drain_ready", req_ready, 1'b0);
    cyc();
    chkB("drain_rd_en2", mem_rd_en, 1'b1);
    mem_rd_ack  = 1'b1;
    mem_rd_data = 32'h1234_5678;
    cyc();
    mem_rd_ack = 1'b0;
    chkB("drain_done_ready", req_ready, 1'b1);
    chkB("drain_no_valid", rsp_valid, 1'b0);

    issue(OP_LW, 32'h10);
    ackAfter(2, 32'hDEAD_BEEF);
    req_valid = 1'b1;
    req_op    = OP_LW;
    req_addr  = 32'h20;
    for (int i = 0; i < 5; i++) begin
      chkB("bp_valid", rsp_valid, 1'b1);
      chkW("bp_data", rsp_data, 32'hDEAD_BEEF);
      chkB("bp_ready", req_ready, 1'b0);
      cyc();
    end
    req_valid = 1'b0;
    consume();
    chkB("bp_released", rsp_valid, 1'b0);
    chkB("bp_no_read", mem_rd_en, 1'b0);

    req_valid = 1'b1;
    req_op    = 3'd6;
    cyc();
    req_valid = 1'b0;
    req_op    = 3'd0;
    chkB("badop_idle", req_ready, 1'b1);

    issue(OP_LBU, 32'h3);
    ackAfter(1, 32'hAABB_CCDD);
    chkW("lbu_data", rsp_data, 32'h0000_00AA);
    req_flush = 1'b1;
    rsp_ready = 1'b1;
    cyc();
    req_flush = 1'b0;
    rsp_ready = 1'b0;
    chkB("hold_flush", rsp_valid, 1'b0);

    issue(OP_LW, 32'h400);
    cyc();
    reset = 1'b0;
    #1;
    chkB("midrst_rd_en", mem_rd_en, 1'b0);
    cyc();
    reset = 1'b1;
    cyc();
    mem_rd_ack  = 1'b1;
    mem_rd_data = 32'h5555_AAAA;
    cyc();
    mem_rd_ack = 1'b0;
    chkB("late_ack_ignored", rsp_valid, 1'b0);
    chkB("late_ack_ready", req_ready, 1'b1);

`ifdef LOAD_TIMEOUT_EN
    issue(OP_LW, 32'h300);
    repeat (3) cyc();
    chkB("to_not_yet", rsp_valid, 1'b0);
    cyc();
    chkB("to_valid", rsp_valid, 1'b1);
    chkW("to_exc", 32'(rsp_exc), 32'h7);
    chkW("to_data", rsp_data, 32'h0);
    mem_rd_ack  = 1'b1;
    mem_rd_data = 32'hFFFF_FFFF;
    cyc();
    mem_rd_ack = 1'b0;
    chkW("to_late_ack", 32'(rsp_exc), 32'h7);
    chkW("to_late_data", rsp_data, 32'h0);
    consume();
`endif

    for (int i = 0; i < 3000; i++) begin
      req_valid   = 1'($urandom % 2);
      req_op      = 3'($urandom % 8);
      req_addr    = $urandom;
      req_flush   = ($urandom % 12) == 0;
      rsp_ready   = 1'($urandom % 2);
      mem_rd_data = $urandom;
      mem_rd_ack  = pendingRead ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
      cyc();
    end
    req_valid  = 1'b0;
    req_flush  = 1'b0;
    mem_rd_ack = 1'b0;
    rsp_ready  = 1'b0;
    cyc();
    checkEn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
